// File: rtl/trace_exec_pkg.sv
// trace_exec_pkg: DEBUG_TRACE_EXEC word layout, marker constant and packing helper
package trace_exec_pkg;
  localparam int DEBUG_TRACE_EXEC_WBDATA_LSB = 0;
  localparam int DEBUG_TRACE_EXEC_WBDATA_MSB = 31;
  localparam int DEBUG_TRACE_EXEC_WBREG_LSB = 32;
  localparam int DEBUG_TRACE_EXEC_WBREG_MSB = 36;
  localparam int DEBUG_TRACE_EXEC_WBEN_LSB = 37;
  localparam int DEBUG_TRACE_EXEC_WBEN_MSB = 37;
  localparam int DEBUG_TRACE_EXEC_INSN_LSB = 38;
  localparam int DEBUG_TRACE_EXEC_INSN_MSB = 69;
  localparam int DEBUG_TRACE_EXEC_PC_LSB = 70;
  localparam int DEBUG_TRACE_EXEC_PC_MSB = 101;
  localparam int DEBUG_TRACE_EXEC_ENABLE_LSB = 102;
  localparam int DEBUG_TRACE_EXEC_ENABLE_MSB = 102;
  localparam int DEBUG_TRACE_EXEC_WIDTH = 103;
  localparam logic [31:0] TRACE_EXEC_MARKER_PC = 32'hFFFF_FFFF;
  typedef logic [DEBUG_TRACE_EXEC_WIDTH-1:0] trace_exec_t;
  function automatic trace_exec_t pack_trace_exec(input logic enable, input logic [31:0] pc,
                                                  input logic [31:0] insn, input logic wben,
                                                  input logic [4:0] wbreg, input logic [31:0] wbdata);
    trace_exec_t t;
    t = '0;
    t[DEBUG_TRACE_EXEC_ENABLE_MSB:DEBUG_TRACE_EXEC_ENABLE_LSB] = enable;
    t[DEBUG_TRACE_EXEC_PC_MSB:DEBUG_TRACE_EXEC_PC_LSB] = pc;
    t[DEBUG_TRACE_EXEC_INSN_MSB:DEBUG_TRACE_EXEC_INSN_LSB] = insn;
    t[DEBUG_TRACE_EXEC_WBEN_MSB:DEBUG_TRACE_EXEC_WBEN_LSB] = wben;
    t[DEBUG_TRACE_EXEC_WBREG_MSB:DEBUG_TRACE_EXEC_WBREG_LSB] = wbreg;
    t[DEBUG_TRACE_EXEC_WBDATA_MSB:DEBUG_TRACE_EXEC_WBDATA_LSB] = wbdata;
    return t;
  endfunction
endpackage

// File: rtl/trace_exec_fifo.sv
// trace_exec_fifo: register FIFO with two ordered push ports and one pop port
module trace_exec_fifo
  import trace_exec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push0,
  input  trace_exec_t din0,
  input  logic        push1,
  input  trace_exec_t din1,
  input  logic        pop,
  output trace_exec_t dout,
  output logic        valid,
  output logic [AW:0] occ
);
  localparam int OW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  trace_exec_t mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      occ <= occ + OW'(push0) + OW'(push1) - OW'(pop);
    end
  // push1 always lands directly behind push0
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= din0;
    if (push1) mem[wr_ptr + AW'(1)] <= din1;
  end
  assign valid = occ != '0;
  assign dout = valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/trace_exec_emitter.sv
// trace_exec_emitter: buffers retired instructions onto the trace bus with drop-count markers or core stall
module trace_exec_emitter
  import trace_exec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter bit STALL_ON_FULL = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_cpu,
  input  logic                              wb_valid,
  input  logic [31:0]                       wb_pc,
  input  logic [31:0]                       wb_insn,
  input  logic                              wb_wben,
  input  logic [4:0]                        wb_wbreg,
  input  logic [31:0]                       wb_wbdata,
  output logic [DEBUG_TRACE_EXEC_WIDTH-1:0] trace,
  output logic                              trace_valid,
  input  logic                              trace_ready,
  output logic                              cpu_stall,
  output logic                              drop_pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [AW:0] occ;
  logic [31:0] drop_cnt, drop_cnt_n;
  logic full, last_slot, has_drop, mark, push0, push1;
  trace_exec_t entry, marker, din0;
  assign entry = pack_trace_exec(1'b1, wb_pc, wb_insn, wb_wben, wb_wbreg, wb_wbdata);
  assign marker = pack_trace_exec(1'b1, TRACE_EXEC_MARKER_PC, drop_cnt, 1'b0, 5'd0, 32'd0);
  // free space comes from registered occupancy only; a same-cycle pop never helps
  always_comb begin
    full = occ == OW'(DEPTH);
    last_slot = occ == OW'(DEPTH - 1);
    has_drop = drop_cnt != '0;
    mark = has_drop && !full;
    push0 = mark || (wb_valid && !full);
    push1 = mark && wb_valid && !last_slot;
    din0 = mark ? marker : entry;
    drop_cnt_n = full ? (wb_valid ? (has_drop ? (&drop_cnt ? drop_cnt : drop_cnt + 32'd1) : 32'd1) : drop_cnt)
                      : {31'd0, mark && wb_valid && last_slot};
  end
  always_ff @(posedge clk or posedge rst_cpu)
    if (rst_cpu) drop_cnt <= '0;
    else drop_cnt <= drop_cnt_n;
  trace_exec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst_cpu),
    .push0(push0),
    .din0(din0),
    .push1(push1),
    .din1(entry),
    .pop(trace_valid && trace_ready),
    .dout(trace),
    .valid(trace_valid),
    .occ(occ)
  );
  assign cpu_stall = STALL_ON_FULL && (occ >= OW'(DEPTH - 1));
  assign drop_pending = has_drop;
endmodule
